// File: rtl/dda_param_loader_if.sv
// Byte-stream bus from the chip input pins into the DDA parameter loader.
// The master drives bytes with a valid strobe; the slave answers with ready.
interface dda_param_loader_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/dda_param_loader.sv
// Byte-serial loader for the DDA: stages a 4-word frame, commits it atomically,
// then pulses the integrator reset and gates the enable (free-running or stepped).
module dda_param_loader #(
    parameter int N           = 16,
    parameter int INIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    dda_param_loader_if.slave   bus,
    input  logic                load_req,
    input  logic                run_en,
    input  logic                step_mode,
    input  logic                step,
    output logic [N-1:0]        icx,
    output logic [N-1:0]        icy,
    output logic [N-1:0]        k,
    output logic [N-1:0]        d,
    output logic                dda_rst,
    output logic                dda_en,
    output logic [1:0]          state_o,
    output logic                loaded,
    output logic [15:0]         step_count
);

    localparam int FRAME_BYTES = N / 2;
    localparam int CNT_W       = $clog2(FRAME_BYTES);
    localparam int INIT_W      = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [INIT_W-1:0] init_q, init_d;
    logic [4*N-1:0]    stage_q, stage_d;
    logic [N-1:0]      icx_q, icx_d, icy_q, icy_d, k_q, k_d, d_q, d_d;
    logic              loaded_q, loaded_d;
    logic [15:0]       sc_q, sc_d;

    logic           accept;
    logic           last_accept;
    logic [4*N-1:0] frame_full;

    assign bus.data_ready = (state_q == ST_LOAD);
    assign accept         = bus.data_valid && (state_q == ST_LOAD);
    assign last_accept    = accept && (cnt_q == LAST_BYTE);
    // Bytes shift in MSB-first, so the oldest byte ends up at the top of icx.
    assign frame_full     = {stage_q[4*N-9:0], bus.data_in};

    assign dda_rst = (state_q == ST_INIT);
    assign dda_en  = (state_q == ST_INIT) ||
                     ((state_q == ST_RUN) && run_en && (!step_mode || step));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        init_d   = init_q;
        stage_d  = stage_q;
        icx_d    = icx_q;
        icy_d    = icy_q;
        k_d      = k_q;
        d_d      = d_q;
        loaded_d = loaded_q;
        sc_d     = sc_q;

        if ((state_q == ST_RUN) && dda_en && (sc_q != 16'hFFFF)) begin
            sc_d = sc_q + 16'd1;
        end

        // A reload request overrides everything, including a final byte in flight.
        if (load_req) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            stage_d = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (last_accept) begin
                        icx_d    = frame_full[4*N-1:3*N];
                        icy_d    = frame_full[3*N-1:2*N];
                        k_d      = frame_full[2*N-1:N];
                        d_d      = frame_full[N-1:0];
                        loaded_d = 1'b1;
                        sc_d     = '0;
                        cnt_d    = '0;
                        stage_d  = '0;
                        init_d   = '0;
                        state_d  = ST_INIT;
                    end else if (accept) begin
                        stage_d = frame_full;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                ST_INIT: begin
                    if (init_q == INIT_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        init_d = init_q + INIT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_LOAD;
            cnt_q    <= '0;
            init_q   <= '0;
            stage_q  <= '0;
            icx_q    <= '0;
            icy_q    <= '0;
            k_q      <= '0;
            d_q      <= '0;
            loaded_q <= 1'b0;
            sc_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            init_q   <= init_d;
            stage_q  <= stage_d;
            icx_q    <= icx_d;
            icy_q    <= icy_d;
            k_q      <= k_d;
            d_q      <= d_d;
            loaded_q <= loaded_d;
            sc_q     <= sc_d;
        end
    end

    assign icx        = icx_q;
    assign icy        = icy_q;
    assign k          = k_q;
    assign d          = d_q;
    assign state_o    = state_q;
    assign loaded     = loaded_q;
    assign step_count = sc_q;

endmodule

// File: tb/tb_dda_param_loader.sv
// Directed bench for dda_param_loader: a per-cycle vector table plus
// hand sequences for reload-in-INIT, reload racing the last byte, and reset mid-INIT.
module tb_dda_param_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req, run_en, step_mode, step;
    logic [15:0] icx, icy, k, d;
    logic        dda_rst, dda_en, loaded;
    logic [1:0]  state_o;
    logic [15:0] step_count;

    dda_param_loader_if bus ();

    dda_param_loader #(.N(16), .INIT_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .load_req   (load_req),
        .run_en     (run_en),
        .step_mode  (step_mode),
        .step       (step),
        .icx        (icx),
        .icy        (icy),
        .k          (k),
        .d          (d),
        .dda_rst    (dda_rst),
        .dda_en     (dda_en),
        .state_o    (state_o),
        .loaded     (loaded),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    // Packed expectation: {ready, state, dda_rst, dda_en, loaded, step_count, icx, icy, k, d}
    typedef struct {
        logic        v;
        logic [7:0]  din;
        logic        lreq, ren, smode, stp;
        logic [85:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    logic [15:0] p_icx, p_icy, p_k, p_d;
    logic        p_ld;

    function automatic void add(input logic v, input logic [7:0] din, input logic lreq,
                                input logic ren, input logic smode, input logic stp,
                                input logic rdy, input logic [1:0] st, input logic drst,
                                input logic den, input logic [15:0] sc);
        vec_t r;
        r.v = v; r.din = din; r.lreq = lreq; r.ren = ren; r.smode = smode; r.stp = stp;
        r.exp = {rdy, st, drst, den, p_ld, sc, p_icx, p_icy, p_k, p_d};
        vecs.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [7:0] din, input logic lreq);
        @(negedge clk);
        bus.data_valid = v;
        bus.data_in    = din;
        load_req       = lreq;
        run_en         = 1'b0;
        step_mode      = 1'b0;
        step           = 1'b0;
    endtask

    initial begin
        logic [7:0]  f1 [8];
        logic [7:0]  f2 [8];
        logic        stps [8];
        logic [15:0] sc;
        logic [85:0] act;

        f1   = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h30, 8'h00};
        f2   = '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h20, 8'h00};
        stps = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        p_icx = '0; p_icy = '0; p_k = '0; p_d = '0; p_ld = 1'b0;
        for (int i = 0; i < 8; i++) add(1'b1, f1[i], 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'd0);
        p_icx = 16'h4000; p_k = 16'h4000; p_d = 16'h3000; p_ld = 1'b1;
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 16'd0);
        for (int i = 0; i < 10; i++) add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 16'(i));
        for (int i = 0; i < 5; i++) add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 16'd10);
        sc = 16'd10;
        for (int i = 0; i < 8; i++) begin
            add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, stps[i], 1'b0, 2'd2, 1'b0, stps[i], sc);
            if (stps[i]) sc = sc + 16'd1;
        end
        add(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 16'd13);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 16'd13);
        for (int i = 0; i < 5; i++) add(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'd13);
        add(1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'd13);
        for (int i = 0; i < 8; i++) begin
            add(1'b1, f2[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'd13);
            if (i < 7) add(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'd13);
        end
        p_icx = 16'h3C00; p_k = 16'h3C00; p_d = 16'h2000;
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 16'd1);

        rst = 1'b1; bus.data_valid = 1'b0; bus.data_in = 8'h00;
        load_req = 1'b0; run_en = 1'b0; step_mode = 1'b0; step = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.data_valid = vecs[i].v;
            bus.data_in    = vecs[i].din;
            load_req       = vecs[i].lreq;
            run_en         = vecs[i].ren;
            step_mode      = vecs[i].smode;
            step           = vecs[i].stp;
            #1;
            act = {bus.data_ready, state_o, dda_rst, dda_en, loaded, step_count, icx, icy, k, d};
            checks++;
            if (act !== vecs[i].exp) begin
                errors++;
                $display("FAIL row%0d: got %h expected %h", i, act, vecs[i].exp);
            end
        end

        // Reload request while the INIT pulse is in progress.
        drv(1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 8; i++) drv(1'b1, 8'(i), 1'b0);
        drv(1'b0, 8'h00, 1'b1);
        #1;
        chk("initA_state", 64'(state_o), 64'd1);
        chk("initA_params", {icx, icy, k, d}, 64'h0102_0304_0506_0708);
        drv(1'b0, 8'h00, 1'b0);
        #1;
        chk("abortA_state", 64'(state_o), 64'd0);
        chk("abortA_ctl", 64'({dda_rst, dda_en, loaded}), 64'b001);
        chk("abortA_icx", 64'(icx), 64'h0102);
        repeat (3) drv(1'b0, 8'h00, 1'b0);
        #1;
        chk("abortA_stay", 64'(state_o), 64'd0);

        // Reload request on the same edge as the final byte: no commit.
        for (int i = 0; i < 7; i++) drv(1'b1, 8'(8'hA1 + i), 1'b0);
        drv(1'b1, 8'hA8, 1'b1);
        drv(1'b0, 8'h00, 1'b0);
        #1;
        chk("raceB_state", 64'(state_o), 64'd0);
        chk("raceB_params", {icx, icy, k, d}, 64'h0102_0304_0506_0708);
        for (int i = 0; i < 8; i++) drv(1'b1, 8'(8'hB1 + i), 1'b0);
        drv(1'b0, 8'h00, 1'b0);
        #1;
        chk("frameB_state", 64'(state_o), 64'd1);
        chk("frameB_params", {icx, icy, k, d}, 64'hB1B2_B3B4_B5B6_B7B8);
        chk("frameB_sc", 64'(step_count), 64'd0);

        // Synchronous reset while still in INIT.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstC_state", 64'(state_o), 64'd0);
        chk("rstC_ctl", 64'({bus.data_ready, dda_rst, dda_en, loaded}), 64'b1000);
        chk("rstC_params", {icx, icy, k, d}, 64'd0);
        chk("rstC_sc", 64'(step_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
